// File: rtl/system_0_sysid_pkg.sv
// rtl/system_0_sysid_pkg.sv - shared types and constants for the sysid checker
package system_0_sysid_pkg;

   // Checker sequencing states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ID   = 3'd1,
      ST_RD_TS   = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } sysid_state_t;

   // Word addresses on the sysid control slave
   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   // Default build-time expected values
   localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
   localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1671595929;

   // Bits needed to hold values 0..n-1, never less than one bit
   function automatic int unsigned width_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/system_0_sysid_read_timer.sv
// rtl/system_0_sysid_read_timer.sv - clear/enable latency counter with terminal count
module system_0_sysid_read_timer
   import system_0_sysid_pkg::*;
#(
   parameter int unsigned LATENCY = 0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   localparam int unsigned CW = width_min1(LATENCY + 1);

   logic [CW-1:0] r_count;

   // Count slave wait cycles; clear wins so each phase restarts from zero
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_terminal = (r_count == CW'(LATENCY));

endmodule

// File: rtl/system_0_sysid_checker.sv
// rtl/system_0_sysid_checker.sv - sysid read/compare sequencer with bounded retry (optional SYSID_AUTOCHECK_EN)
module system_0_sysid_checker
   import system_0_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
   parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
   parameter int unsigned READ_LATENCY       = 0,
   parameter int unsigned MAX_RETRIES        = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_mismatch,
   output logic        ts_mismatch,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts
);

   localparam int unsigned RW = width_min1(MAX_RETRIES + 1);

   sysid_state_t  r_state;
   sysid_state_t  w_next;
   logic [RW-1:0] r_retry;
   logic          r_pass;
   logic          r_id_mm;
   logic          r_ts_mm;
   logic [31:0]   r_cap_id;
   logic [31:0]   r_cap_ts;
   logic          w_start;
   logic          w_rd_phase;
   logic          w_terminal;
   logic          w_id_mm;
   logic          w_ts_mm;
   logic          w_any_mm;
   logic          w_can_retry;

`ifdef SYSID_AUTOCHECK_EN
   logic r_auto;

   // One-shot that stands in for a start pulse on the first edge out of reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_auto <= 1'b1;
      end else begin
         r_auto <= 1'b0;
      end
   end

   assign w_start = start | r_auto;
`else
   assign w_start = start;
`endif

   assign w_rd_phase  = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
   assign w_id_mm     = (r_cap_id != EXPECTED_ID);
   assign w_ts_mm     = (r_cap_ts != EXPECTED_TIMESTAMP);
   assign w_any_mm    = w_id_mm | w_ts_mm;
   assign w_can_retry = (r_retry < RW'(MAX_RETRIES));

   // Restart the latency count at the start of every read phase
   system_0_sysid_read_timer #(
      .LATENCY (READ_LATENCY)
   ) u_timer (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_clear    (!w_rd_phase || w_terminal),
      .i_enable   (w_rd_phase),
      .o_terminal (w_terminal)
   );

   // State register; reset aborts any check in flight
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: two read phases, a compare, then retry or finish
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_start) w_next = ST_RD_ID;
         ST_RD_ID:   if (w_terminal) w_next = ST_RD_TS;
         ST_RD_TS:   if (w_terminal) w_next = ST_COMPARE;
         ST_COMPARE: w_next = (w_any_mm && w_can_retry) ? ST_RD_ID : ST_DONE;
         ST_DONE:    w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   // Slave strobes and status decoded from the current state
   always_comb begin
      sysid_read    = w_rd_phase;
      sysid_address = (r_state == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
      busy          = (r_state != ST_IDLE);
      done          = (r_state == ST_DONE);
   end

   // Captures, verdict flags and retry count; verdict lands on entry to DONE
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_retry  <= '0;
         r_pass   <= 1'b0;
         r_id_mm  <= 1'b0;
         r_ts_mm  <= 1'b0;
         r_cap_id <= '0;
         r_cap_ts <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_retry <= '0;
                  r_pass  <= 1'b0;
                  r_id_mm <= 1'b0;
                  r_ts_mm <= 1'b0;
               end
            end
            ST_RD_ID: if (w_terminal) r_cap_id <= sysid_readdata;
            ST_RD_TS: if (w_terminal) r_cap_ts <= sysid_readdata;
            ST_COMPARE: begin
               r_id_mm <= w_id_mm;
               r_ts_mm <= w_ts_mm;
               if (w_any_mm && w_can_retry) begin
                  r_retry <= r_retry + 1'b1;
               end else begin
                  r_pass <= !w_any_mm;
               end
            end
            default: ;
         endcase
      end
   end

   assign pass        = r_pass;
   assign id_mismatch = r_id_mm;
   assign ts_mismatch = r_ts_mm;
   assign captured_id = r_cap_id;
   assign captured_ts = r_cap_ts;

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// tb/tb_system_0_sysid_checker.sv - directed vector bench for the sysid checker
module tb_system_0_sysid_checker;

   localparam logic [31:0] TS_GOOD = 32'd1671595929;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start0, start2;
   logic        read0, addr0, busy0, done0, pass0, idmm0, tsmm0;
   logic        read2, addr2, busy2, done2, pass2, idmm2, tsmm2;
   logic [31:0] rdata0, cid0, cts0, rdata2, cid2, cts2;
   logic [31:0] id_val, ts_val;
   int          bad_first;
   int          id_reads;
   int          checks = 0;
   int          errors = 0;

   // 100 MHz clock
   always #5 clock = ~clock;

   // Slave for dut0: timestamp can be corrupted for the first bad_first passes
   assign rdata0 = !addr0 ? id_val : ((id_reads <= bad_first) ? 32'hDEAD_BEEF : ts_val);
   assign rdata2 = addr2 ? TS_GOOD : 32'd0;

   system_0_sysid_checker #(.READ_LATENCY(0), .MAX_RETRIES(3)) dut0 (
      .clock(clock), .reset_n(reset_n), .start(start0),
      .sysid_address(addr0), .sysid_read(read0), .sysid_readdata(rdata0),
      .busy(busy0), .done(done0), .pass(pass0),
      .id_mismatch(idmm0), .ts_mismatch(tsmm0),
      .captured_id(cid0), .captured_ts(cts0)
   );

   system_0_sysid_checker #(.READ_LATENCY(2), .MAX_RETRIES(3)) dut2 (
      .clock(clock), .reset_n(reset_n), .start(start2),
      .sysid_address(addr2), .sysid_read(read2), .sysid_readdata(rdata2),
      .busy(busy2), .done(done2), .pass(pass2),
      .id_mismatch(idmm2), .ts_mismatch(tsmm2),
      .captured_id(cid2), .captured_ts(cts2)
   );

   typedef struct {
      logic [31:0] id;
      logic [31:0] ts;
      int          bad_first;
      logic        exp_pass;
      logic        exp_idmm;
      logic        exp_tsmm;
      int          exp_lat;
      int          exp_reads;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Run one check on dut0; optionally re-pulse start in RD_TS and DONE cycles
   task automatic run0(input bit inj, output int lat, output int dones);
      lat      = -1;
      dones    = 0;
      id_reads = 0;
      start0   = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clock);
         start0 = 1'b0;
         if (read0 && !addr0) id_reads++;
         if (inj && read0 && addr0) start0 = 1'b1;
         if (done0) begin
            dones++;
            if (lat < 0) lat = c;
            if (inj) start0 = 1'b1;
         end
         if (lat > 0 && c >= lat + 3) break;
      end
      start0 = 1'b0;
   endtask

   initial begin
      int lat, dones, r0, r1;

      vecs[0] = '{32'd0,         TS_GOOD,      0, 1'b1, 1'b0, 1'b0,  4, 1};
      vecs[1] = '{32'h1,         TS_GOOD,      0, 1'b0, 1'b1, 1'b0, 13, 4};
      vecs[2] = '{32'd0,         32'd0,        0, 1'b0, 1'b0, 1'b1, 13, 4};
      vecs[3] = '{32'hFFFF_FFFF, 32'd12345,    0, 1'b0, 1'b1, 1'b1, 13, 4};
      vecs[4] = '{32'd0,         TS_GOOD,      1, 1'b1, 1'b0, 1'b0,  7, 2};

      id_val    = 32'd0;
      ts_val    = TS_GOOD;
      bad_first = 0;
      id_reads  = 0;
      start0    = 1'b0;
      start2    = 1'b0;
      reset_n   = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_read", {31'd0, read0}, 32'd0);
      chk("rst_done", {31'd0, done0}, 32'd0);
      chk("rst_pass", {31'd0, pass0}, 32'd0);
      chk("rst_cid", cid0, 32'd0);
      chk("rst_busy2", {31'd0, busy2}, 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
`ifdef SYSID_AUTOCHECK_EN
      repeat (20) @(negedge clock);
`endif

      // Table of whole-check outcomes on the zero-latency instance
      for (int i = 0; i < 5; i++) begin
         id_val    = vecs[i].id;
         ts_val    = vecs[i].ts;
         bad_first = vecs[i].bad_first;
         run0(1'b0, lat, dones);
         chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_reads", i), id_reads, vecs[i].exp_reads);
         chk($sformatf("v%0d_dones", i), dones, 32'd1);
         chk($sformatf("v%0d_pass", i), {31'd0, pass0}, {31'd0, vecs[i].exp_pass});
         chk($sformatf("v%0d_idmm", i), {31'd0, idmm0}, {31'd0, vecs[i].exp_idmm});
         chk($sformatf("v%0d_tsmm", i), {31'd0, tsmm0}, {31'd0, vecs[i].exp_tsmm});
         chk($sformatf("v%0d_cid", i), cid0, vecs[i].id);
         chk($sformatf("v%0d_cts", i), cts0, vecs[i].ts);
         chk($sformatf("v%0d_idle", i), {31'd0, busy0}, 32'd0);
      end
      bad_first = 0;
      id_val    = 32'd0;
      ts_val    = TS_GOOD;

      // Latency-2 instance: three-cycle read phases, done in cycle 8
      lat = -1; dones = 0; r0 = 0; r1 = 0;
      start2 = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         start2 = 1'b0;
         if (read2 && !addr2) r0++;
         if (read2 && addr2) r1++;
         if (done2) begin
            dones++;
            if (lat < 0) lat = c;
         end
         if (lat > 0 && c >= lat + 2) break;
      end
      chk("l2_lat", lat, 32'd8);
      chk("l2_id_cycles", r0, 32'd3);
      chk("l2_ts_cycles", r1, 32'd3);
      chk("l2_dones", dones, 32'd1);
      chk("l2_cts", cts2, TS_GOOD);
      chk("l2_pass", {31'd0, pass2}, 32'd1);

      // Start re-pulsed during RD_TS and DONE is ignored
      run0(1'b1, lat, dones);
      chk("inj_lat", lat, 32'd4);
      chk("inj_dones", dones, 32'd1);
      chk("inj_idle", {31'd0, busy0}, 32'd0);

      // Reset asserted in RD_TS clears everything at once
      start0 = 1'b1;
      @(negedge clock);
      start0 = 1'b0;
      @(negedge clock);
      chk("pre_rst_rdts", {31'd0, read0 & addr0}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_busy", {31'd0, busy0}, 32'd0);
      chk("mid_read", {31'd0, read0}, 32'd0);
      chk("mid_addr", {31'd0, addr0}, 32'd0);
      chk("mid_pass", {31'd0, pass0}, 32'd0);
      chk("mid_cid", cid0, 32'd0);
      chk("mid_cts", cts0, 32'd0);
      dones = 0;
      repeat (4) begin
         @(negedge clock);
         if (done0) dones++;
      end
      chk("mid_no_done", dones, 32'd0);
      reset_n = 1'b1;
`ifdef SYSID_AUTOCHECK_EN
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clock);
         if (done0 && lat < 0) lat = c;
      end
      chk("auto_lat", lat, 32'd4);
      chk("auto_pass", {31'd0, pass0}, 32'd1);
`else
      repeat (3) @(negedge clock);
      chk("post_rst_idle", {31'd0, busy0}, 32'd0);
      run0(1'b0, lat, dones);
      chk("post_rst_lat", lat, 32'd4);
      chk("post_rst_pass", {31'd0, pass0}, 32'd1);
      chk("post_rst_cts", cts0, TS_GOOD);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
